shake_arbiter: RTL and testbench

SHAKE_ARBITER -- requirements
Module: shake_arbiter

---
 rtl/shake_arbiter.sv | 123 ++++++++++++
 tb/tb_shake_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake_arbiter.sv
// shake_arbiter
// Shares one keccak_top core between two requesters. A requester raises its
// req bit for the whole session. The arbiter grants the core to one requester
// and routes that requester's streams to the core without adding any latency.
// When the owner drops req, the arbiter spends one FLUSH cycle pulsing
// k_force_done, then returns to IDLE.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : asynchronous reset, active low
//   req[1:0]      : per-requester session request
//   gnt[1:0]      : one-hot grant, asserted only while BUSY
//   r_din         : requester input words, requester i at [i*WIN +: WIN]
//   r_din_valid   : per-requester input valid
//   r_din_ready   : per-requester input ready (owner only)
//   r_dout        : core output word, shared; qualified by r_dout_valid
//   r_dout_valid  : per-requester output valid (owner only)
//   r_dout_ready  : per-requester output ready
//   k_din/_valid  : word and valid to the core
//   k_din_ready   : core input ready
//   k_dout/_valid : word and valid from the core
//   k_dout_ready  : ready to the core
//   k_force_done  : single-cycle flush pulse to the core
module shake_arbiter #(
    parameter int WIN  = 32,
    parameter int WOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic [2*WIN-1:0]  r_din,
    input  logic [1:0]        r_din_valid,
    output logic [1:0]        r_din_ready,
    output logic [WOUT-1:0]   r_dout,
    output logic [1:0]        r_dout_valid,
    input  logic [1:0]        r_dout_ready,
    output logic [WIN-1:0]    k_din,
    output logic              k_din_valid,
    input  logic              k_din_ready,
    input  logic [WOUT-1:0]   k_dout,
    input  logic              k_dout_valid,
    output logic              k_dout_ready,
    output logic              k_force_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   last_q, last_d;

    logic       busy;
    logic [1:0] owner_mask;

    // last resets to 1 so the first contended grant after reset goes to requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // Both requesting: round-robin against the previous owner.
                    if (req == 2'b11) begin
                        sel_d = ~last_q;
                    end else begin
                        sel_d = req[1];
                    end
                    // last tracks the owner from the moment BUSY is entered.
                    last_d  = sel_d;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The owner's last handshake completes combinationally in this
                // cycle; only the next-state changes.
                if (!req[sel_q]) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == BUSY);
    assign owner_mask = sel_q ? 2'b10 : 2'b01;

    // Combinational routing; every handshake qualifier is gated by busy so the
    // core and the non-owner see nothing outside a session.
    always_comb begin
        gnt          = busy ? owner_mask : 2'b00;
        k_din        = sel_q ? r_din[2*WIN-1:WIN] : r_din[WIN-1:0];
        k_din_valid  = busy & r_din_valid[sel_q];
        r_din_ready  = (busy & k_din_ready) ? owner_mask : 2'b00;
        r_dout       = k_dout;
        r_dout_valid = (busy & k_dout_valid) ? owner_mask : 2'b00;
        k_dout_ready = busy & r_dout_ready[sel_q];
        k_force_done = (state_q == FLUSH);
    end

endmodule

// File: tb/tb_shake_arbiter.sv
module tb_shake_arbiter;

    localparam int WIN  = 16;
    localparam int WOUT = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [2*WIN-1:0]  r_din;
    logic [1:0]        r_din_valid;
    logic [1:0]        r_din_ready;
    logic [WOUT-1:0]   r_dout;
    logic [1:0]        r_dout_valid;
    logic [1:0]        r_dout_ready;
    logic [WIN-1:0]    k_din;
    logic              k_din_valid;
    logic              k_din_ready;
    logic [WOUT-1:0]   k_dout;
    logic              k_dout_valid;
    logic              k_dout_ready;
    logic              k_force_done;

    always #5 clk = ~clk;

    shake_arbiter #(.WIN(WIN), .WOUT(WOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .r_din(r_din), .r_din_valid(r_din_valid), .r_din_ready(r_din_ready),
        .r_dout(r_dout), .r_dout_valid(r_dout_valid), .r_dout_ready(r_dout_ready),
        .k_din(k_din), .k_din_valid(k_din_valid), .k_din_ready(k_din_ready),
        .k_dout(k_dout), .k_dout_valid(k_dout_valid), .k_dout_ready(k_dout_ready),
        .k_force_done(k_force_done)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the core (-1 = nobody), how many cycles of
    // post-session cool-down remain, and who owned it last.
    int m_owner;
    int m_cool;
    int m_last;

    logic [WIN-1:0]  inw  [4];
    logic [WOUT-1:0] outw [8];
    logic [WIN-1:0]  rx   [$];
    logic [WOUT-1:0] got  [$];
    int ti, ko, owner_bit, w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cool  = 0;
        m_last  = 1;
    endtask

    // One clock edge of the arbitration rules, using req as sampled at the edge.
    task automatic model_edge();
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_cool  = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (req != 2'b00) begin
            if (req == 2'b11) m_owner = 1 - m_last;
            else              m_owner = req[1] ? 1 : 0;
            m_last = m_owner;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        logic       busy;
        int         o;
        busy = (m_owner >= 0);
        o    = busy ? m_owner : 0;
        eg   = busy ? (2'b01 << o) : 2'b00;
        chk("gnt",          64'(gnt),          64'(eg));
        chk("k_force_done", 64'(k_force_done), 64'(!busy && m_cool == 1));
        chk("k_din_valid",  64'(k_din_valid),  64'(busy && r_din_valid[o]));
        chk("r_din_ready",  64'(r_din_ready),  64'(k_din_ready ? eg : 2'b00));
        chk("r_dout_valid", 64'(r_dout_valid), 64'(k_dout_valid ? eg : 2'b00));
        chk("k_dout_ready", 64'(k_dout_ready), 64'(busy && r_dout_ready[o]));
        chk("r_dout",       64'(r_dout),       64'(k_dout));
        if (busy) chk("k_din", 64'(k_din), 64'(r_din[o*WIN +: WIN]));
    endtask

    task automatic noise();
        r_din        = {WIN'($urandom), WIN'($urandom)};
        r_din_valid  = 2'($urandom);
        r_dout_ready = 2'($urandom);
        k_din_ready  = 1'($urandom);
        k_dout       = WOUT'($urandom);
        k_dout_valid = 1'($urandom);
    endtask

    task automatic step_edge();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        step_edge();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted before any clock edge, with every input active.
        rst = 1'b1;
        req = 2'b11;
        noise();
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            noise();
            r_din_valid = 2'b11;
            #1;
            check_outputs();
            @(posedge clk);
            #1;
        end

        // Release away from the clock edge; nothing changes until the next edge.
        rst = 1'b1;
        noise();
        cycle();
        chk("contention_first_gnt", 64'(gnt), 64'(2'b01));
        for (int i = 0; i < 3; i++) begin
            noise();
            cycle();
        end
        req = 2'b10;
        noise();
        cycle();
        chk("contention_flush", 64'(k_force_done), 64'(1'b1));
        noise();
        cycle();
        chk("contention_idle_gnt", 64'(gnt), 64'(2'b00));
        chk("contention_idle_fd", 64'(k_force_done), 64'(1'b0));
        noise();
        cycle();
        chk("contention_second_gnt", 64'(gnt), 64'(2'b10));
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            noise();
            cycle();
        end

        // Single requester streams 4 words in and 8 words out.
        for (int i = 0; i < 4; i++) inw[i]  = WIN'($urandom);
        for (int i = 0; i < 8; i++) outw[i] = WOUT'($urandom);
        rx.delete();
        got.delete();
        ti = 0;
        ko = 0;
        req = 2'b01;
        noise();
        cycle();
        chk("grant_latency", 64'(gnt), 64'(2'b01));
        for (int c = 0; c < 300 && !(ti == 4 && got.size() == 8); c++) begin
            noise();
            r_din[WIN-1:0] = inw[(ti < 4) ? ti : 3];
            r_din_valid[0] = (ti < 4) && ($urandom_range(0, 2) != 0);
            k_dout         = outw[(ko < 8) ? ko : 7];
            k_dout_valid   = (ko < 8) && ($urandom_range(0, 1) != 0);
            #1;
            check_outputs();
            if (r_din_valid[0] && r_din_ready[0]) ti++;
            if (k_din_valid && k_din_ready) rx.push_back(k_din);
            if (k_dout_valid && k_dout_ready) ko++;
            if (r_dout_valid[0] && r_dout_ready[0]) got.push_back(r_dout);
            step_edge();
        end
        chk("stream_in_count", 64'(rx.size()), 64'(4));
        chk("stream_out_count", 64'(got.size()), 64'(8));
        if (rx.size() == 4)
            for (int i = 0; i < 4; i++) chk("stream_in_word", 64'(rx[i]), 64'(inw[i]));
        if (got.size() == 8)
            for (int i = 0; i < 8; i++) chk("stream_out_word", 64'(got[i]), 64'(outw[i]));
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            noise();
            cycle();
        end

        // Reset in the middle of a requester-0 session.
        req = 2'b01;
        noise();
        cycle();
        r_din_valid  = 2'b11;
        k_din_ready  = 1'b1;
        k_dout_valid = 1'b1;
        r_dout_ready = 2'b11;
        #1;
        check_outputs();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_async_gnt", 64'(gnt), 64'(2'b00));
        chk("rst_async_k_din_valid", 64'(k_din_valid), 64'(1'b0));
        chk("rst_async_k_dout_ready", 64'(k_dout_ready), 64'(1'b0));
        chk("rst_async_force_done", 64'(k_force_done), 64'(1'b0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        rst = 1'b1;
        req = 2'b11;
        noise();
        cycle();
        chk("post_reset_first_gnt", 64'(gnt), 64'(2'b01));

        // Fairness: both keep requesting, owner drops req for one cycle.
        for (int s = 0; s < 6; s++) begin
            w = 0;
            while (gnt == 2'b00 && w < 10) begin
                noise();
                cycle();
                w++;
            end
            chk("fair_owner", 64'(gnt), 64'((s % 2 == 0) ? 2'b01 : 2'b10));
            owner_bit = gnt[1] ? 1 : 0;
            for (int i = 0; i < 2; i++) begin
                noise();
                cycle();
            end
            req = (owner_bit == 1) ? 2'b01 : 2'b10;
            noise();
            cycle();
            req = 2'b11;
        end
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            noise();
            cycle();
        end

        // Backpressure: requester 0 stalls output for 10 cycles.
        for (int i = 0; i < 3; i++) outw[i] = WOUT'($urandom);
        got.delete();
        ko = 0;
        req = 2'b01;
        noise();
        cycle();
        for (int c = 0; c < 10; c++) begin
            noise();
            r_dout_ready[0] = 1'b0;
            k_dout_valid    = 1'b1;
            k_dout          = outw[0];
            #1;
            check_outputs();
            chk("bp_k_dout_ready", 64'(k_dout_ready), 64'(1'b0));
            step_edge();
        end
        for (int c = 0; c < 100 && got.size() < 3; c++) begin
            noise();
            k_dout       = outw[(ko < 3) ? ko : 2];
            k_dout_valid = (ko < 3);
            #1;
            check_outputs();
            if (k_dout_valid && k_dout_ready) ko++;
            if (r_dout_valid[0] && r_dout_ready[0]) got.push_back(r_dout);
            step_edge();
        end
        chk("bp_word_count", 64'(got.size()), 64'(3));
        chk("bp_core_pops", 64'(ko), 64'(3));
        if (got.size() == 3)
            for (int i = 0; i < 3; i++) chk("bp_word", 64'(got[i]), 64'(outw[i]));

        // Non-owner noise while requester 0 holds the grant.
        for (int c = 0; c < 6; c++) begin
            noise();
            r_din_valid  = {1'(c & 1), 1'b1};
            r_dout_ready = {1'(~c & 1), 1'b0};
            #1;
            check_outputs();
            chk("noise_k_din_valid", 64'(k_din_valid), 64'(1'b1));
            chk("noise_k_dout_ready", 64'(k_dout_ready), 64'(1'b0));
            chk("noise_r_din_ready1", 64'(r_din_ready[1]), 64'(1'b0));
            step_edge();
        end
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            noise();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
